gpio_seg7_scan: RTL and testbench
=================================

Name: gpio_seg7_scan

Overview:
- Downstream consumer of the 32-bit AHB PIO output word (GPIO). Drives a multiplexed NUM_DIGITS-digit 7-segment display, one hex nibble per digit.
- Time-multiplexes the digits and applies PWM brightness.
- Latches the input word only at frame boundaries, so a mid-scan register write never tears a frame.
- Sits in the SOPC top between the PIO slave and the board display pins.

Parameters:
- CLK_DIV, 1000, HCLK cycles per PWM sub-phase; legal range >= 1.
- NUM_DIGITS, 8, number of digits scanned; legal range 1..8; digit i shows DATA_IN[4i+3:4i].
- AN_ACTIVE_LOW, 1, 1 = anode enables are driven low when active.
- SEG_ACTIVE_LOW, 1, 1 = segment and DP outputs are driven low when lit.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset
- DATA_IN  in  32  display word (GPIO from the PIO)
- DP_IN  in  8  decimal point per digit; bit i belongs to digit i
- BRIGHT  in  4  brightness; on-time is (BRIGHT+1)/16 of each digit slot
- LZB_EN  in  1  leading-zero blanking enable
- SEG  out  7  segments {g,f,e,d,c,b,a}; bit0 = a
- DP  out  1  decimal point
- AN  out  NUM_DIGITS  digit enables
- FRAME_DONE  out  1  single-cycle pulse at each frame boundary

Behaviour:
- Reset:
  - HRESETn is asynchronous and active-low; clock is HCLK.
  - Reset clears prescaler, phase, digit index and shadow registers to 0.
  - AN, SEG and DP reset to their inactive levels: all-ones when the polarity parameter is 1, all-zeros otherwise.
  - FRAME_DONE resets to 0.
  - Reset asserted mid-frame returns outputs to inactive immediately. Scanning restarts at digit 0, phase 0, with shadow = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - sub_tick is asserted in the cycle where the count equals CLK_DIV-1.
  - With CLK_DIV = 1, sub_tick is asserted every cycle.
- Phase counter: 4 bits, increments on each sub_tick, wraps 15 -> 0.
- Digit index:
  - Advances on sub_tick when phase = 15, wrapping NUM_DIGITS-1 -> 0.
  - Frame length = NUM_DIGITS*16*CLK_DIV cycles.
- Frame boundary: the cycle where the digit index wraps to 0.
  - shadow_data <= DATA_IN; shadow_dp <= DP_IN; shadow_bright <= BRIGHT; shadow_lzb <= LZB_EN.
  - FRAME_DONE is asserted in the following cycle for exactly 1 cycle.
  - Input changes at any other time have no visible effect until the next boundary.
- Digit on-condition: phase <= shadow_bright.
  - BRIGHT = 15 gives 100% on-time.
  - BRIGHT = 0 gives 1/16 on-time.
- Leading-zero blanking: digit i (i > 0) is blanked when shadow_lzb = 1 and every nibble i..NUM_DIGITS-1 of shadow_data is 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps AN inactive; its DP is also suppressed.
- Hex encoding, active-high (0..F):
  - 0-7: 3F 06 5B 4F 66 6D 7D 07
  - 8-F: 7F 6F 77 7C 39 5E 79 71
  - Outputs are inverted when SEG_ACTIVE_LOW = 1.
- Outputs:
  - All outputs are registered: AN/SEG/DP reflect the counter state of the previous cycle (1-cycle latency).
  - Exactly one AN bit is active when the current digit is on and not blanked; otherwise none.
  - SEG and DP change only together with AN, so there is no ghosting.
- Simultaneous events: a DATA_IN change in the boundary cycle is captured, since the capture samples DATA_IN in that cycle.

Decomposition:
- Package gpio_seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - the sub-phase count constant (16);
  - the BRIGHT width constant.
- Sub-module seg7_hex_decode: combinational nibble -> 7-bit active-high segment pattern. Instantiated once, on the selected nibble.
- Counters, shadow registers, blanking and polarity logic stay in gpio_seg7_scan.

Test Plan:
Settings: CLK_DIV=2, NUM_DIGITS=8, active-low polarity (frame = 256 cycles).
1. Reset, then DATA_IN=0x12345678, BRIGHT=15 -> after the first boundary:
   - digit 0 AN=8'hFE with SEG=~7F (8) for 32 cycles;
   - digit 7 AN=8'h7F with SEG=~06 (1);
   - FRAME_DONE pulses every 256 cycles.
2. BRIGHT=3 -> each AN bit is active 8 of every 32 cycles (phases 0..3) and inactive for the remaining 24.
3. DATA_IN changes 0x0 -> 0xFFFFFFFF mid-frame -> SEG stays ~3F until the next FRAME_DONE, then shows ~71 on all digits.
4. LZB_EN=1, DATA_IN=0x00000A05 -> AN never activates digits 3..7; digits 2,1,0 show ~77, ~3F, ~6D.
5. LZB_EN=1, DATA_IN=0 -> only digit 0 is lit (~3F); DP_IN=8'h80 gives DP inactive because digit 7 is blanked.
6. Assert HRESETn low mid-frame -> AN=8'hFF, SEG=7'h7F, DP=1, FRAME_DONE=0 immediately. After release, the first FRAME_DONE arrives 256 cycles later.

Source files
------------

// File: rtl/gpio_seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment table,
// sub-phase count and brightness width.
package gpio_seg7_pkg;

  localparam int SUB_PHASES = 16;
  localparam int PHASE_W    = $clog2(SUB_PHASES);
  localparam int BRIGHT_W   = 4;

  // Active-high {g,f,e,d,c,b,a} patterns; index 15 sits leftmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/gpio_seg7_scan_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import gpio_seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/gpio_seg7_scan.sv
// Multiplexed hex display driver for the PIO output word, with PWM
// brightness, leading-zero blanking and frame-aligned input capture.
module gpio_seg7_scan
  import gpio_seg7_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int NUM_DIGITS     = 8,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           DATA_IN,
  input  logic [7:0]            DP_IN,
  input  logic [3:0]            BRIGHT,
  input  logic                  LZB_EN,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  FRAME_DONE
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [PRE_W-1:0]      r_presc;
  logic [PHASE_W-1:0]    r_phase;
  logic [DIG_W-1:0]      r_digit;
  logic [31:0]           r_shadowData;
  logic [7:0]            r_shadowDp;
  logic [BRIGHT_W-1:0]   r_shadowBright;
  logic                  r_shadowLzb;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic                  r_frameDone;

  logic                  w_subTick;
  logic                  w_phaseEnd;
  logic                  w_boundary;
  logic [3:0]            w_nibble;
  logic [6:0]            w_segHigh;
  logic                  w_upperZero;
  logic                  w_blank;
  logic                  w_on;
  logic [NUM_DIGITS-1:0] w_anHigh;
  logic                  w_dpHigh;

  assign w_subTick  = (r_presc == PRE_W'(CLK_DIV - 1));
  assign w_phaseEnd = w_subTick && (r_phase == PHASE_W'(SUB_PHASES - 1));
  assign w_boundary = w_phaseEnd && (r_digit == DIG_W'(NUM_DIGITS - 1));

  assign w_nibble = r_shadowData[4*r_digit +: 4];

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_segHigh)
  );

  // A digit is a leading zero when it and every more significant digit is 0.
  always_comb begin
    w_upperZero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(r_digit)) && (r_shadowData[4*j +: 4] != 4'h0))
        w_upperZero = 1'b0;
    end
  end

  assign w_blank  = r_shadowLzb && (r_digit != '0) && w_upperZero;
  assign w_on     = (r_phase <= r_shadowBright) && !w_blank;
  assign w_anHigh = w_on ? (NUM_DIGITS'(1) << r_digit) : '0;
  assign w_dpHigh = w_on && r_shadowDp[r_digit];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_presc <= '0;
      r_phase <= '0;
      r_digit <= '0;
    end else begin
      r_presc <= w_subTick ? '0 : r_presc + 1'b1;
      if (w_subTick)
        r_phase <= r_phase + 1'b1;
      if (w_phaseEnd)
        r_digit <= (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + 1'b1;
    end
  end

  // Inputs are only sampled as the scan wraps, so a frame never tears.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_shadowData   <= '0;
      r_shadowDp     <= '0;
      r_shadowBright <= '0;
      r_shadowLzb    <= 1'b0;
      r_frameDone    <= 1'b0;
    end else begin
      r_frameDone <= w_boundary;
      if (w_boundary) begin
        r_shadowData   <= DATA_IN;
        r_shadowDp     <= DP_IN;
        r_shadowBright <= BRIGHT;
        r_shadowLzb    <= LZB_EN;
      end
    end
  end

  // Segments are gated with the anode so nothing ghosts onto a dark slot.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else begin
      r_an  <= w_anHigh ^ AN_OFF;
      r_seg <= (w_on ? w_segHigh : 7'h00) ^ SEG_OFF;
      r_dp  <= w_dpHigh ^ DP_OFF;
    end
  end

  assign AN         = r_an;
  assign SEG        = r_seg;
  assign DP         = r_dp;
  assign FRAME_DONE = r_frameDone;

endmodule

// File: tb/tb_gpio_seg7_scan.sv
// Randomized bench for gpio_seg7_scan against a frame/slot arithmetic model.
module tb_gpio_seg7_scan;

  localparam int CLK_DIV    = 2;
  localparam int NUM_DIGITS = 8;
  localparam int FRAME      = NUM_DIGITS * 16 * CLK_DIV;
  localparam int SLOT       = 16 * CLK_DIV;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] dataIn;
  logic [7:0]  dpIn;
  logic [3:0]  bright;
  logic        lzbEn;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frameDone;

  int total = 0;
  int bad   = 0;
  int t;
  int n;

  logic [31:0] mData;
  logic [7:0]  mDp;
  logic [3:0]  mBright;
  logic        mLzb;
  logic [7:0]  expAn;
  logic [6:0]  expSeg;
  logic        expDp;
  logic        expFd;

  logic [6:0] segRef [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  gpio_seg7_scan #(
    .CLK_DIV        (CLK_DIV),
    .NUM_DIGITS     (NUM_DIGITS),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .HCLK       (clk),
    .HRESETn    (resetN),
    .DATA_IN    (dataIn),
    .DP_IN      (dpIn),
    .BRIGHT     (bright),
    .LZB_EN     (lzbEn),
    .SEG        (seg),
    .DP         (dp),
    .AN         (an),
    .FRAME_DONE (frameDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s t=%0d got=%h expected=%h", tag, t, got, want);
    end
  endtask

  task automatic checkAll();
    checkOutput("an", 32'(an), 32'(expAn));
    checkOutput("seg", 32'(seg), 32'(expSeg));
    checkOutput("dp", 32'(dp), 32'(expDp));
    checkOutput("frame_done", 32'(frameDone), 32'(expFd));
  endtask

  task automatic setInactive();
    expAn  = 8'hFF;
    expSeg = 7'h7F;
    expDp  = 1'b1;
    expFd  = 1'b0;
  endtask

  task automatic modelReset();
    t       = 0;
    mData   = '0;
    mDp     = '0;
    mBright = '0;
    mLzb    = 1'b0;
  endtask

  // One clock: predict what cycle t's counters produce, capture at the
  // frame's last cycle, then step and compare.
  task automatic applyStimulus();
    int p, dig, ph;
    logic on;
    logic [3:0] nib;
    p   = t % FRAME;
    dig = p / SLOT;
    ph  = (p % SLOT) / CLK_DIV;
    on  = (ph <= int'(mBright)) &&
          !(mLzb && (dig > 0) && ((mData >> (4 * dig)) == 32'h0));
    nib    = 4'((mData >> (4 * dig)) & 32'hF);
    expAn  = on ? ~(8'h01 << dig) : 8'hFF;
    expSeg = on ? ~segRef[nib] : 7'h7F;
    expDp  = (on && mDp[dig]) ? 1'b0 : 1'b1;
    expFd  = (p == FRAME - 1);
    if (p == FRAME - 1) begin
      mData   = dataIn;
      mDp     = dpIn;
      mBright = bright;
      mLzb    = lzbEn;
    end
    @(posedge clk);
    @(negedge clk);
    t++;
    checkAll();
  endtask

  task automatic runCycles(input int cycles);
    repeat (cycles) applyStimulus();
  endtask

  initial begin
    resetN = 1'b0;
    dataIn = 32'h12345678;
    dpIn   = 8'h00;
    bright = 4'd15;
    lzbEn  = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    setInactive();
    checkAll();
    resetN = 1'b1;
    modelReset();
    checkAll();

    $display("[TB] full brightness, 0x12345678");
    dpIn = 8'(($urandom));
    runCycles(3 * FRAME);

    $display("[TB] brightness 3");
    bright = 4'd3;
    runCycles(2 * FRAME + 17);

    $display("[TB] mid-frame data change");
    dataIn = 32'h0;
    bright = 4'd15;
    runCycles(FRAME);
    while ((t % FRAME) != 100) applyStimulus();
    dataIn = 32'hFFFFFFFF;
    runCycles(2 * FRAME);

    $display("[TB] leading-zero blanking 0xA05");
    lzbEn  = 1'b1;
    dataIn = 32'h00000A05;
    dpIn   = 8'hFF;
    runCycles(2 * FRAME);

    $display("[TB] blanking all-zero with DP on digit 7");
    dataIn = 32'h0;
    dpIn   = 8'h80;
    runCycles(2 * FRAME);

    $display("[TB] random traffic");
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        dataIn = $urandom;
        dataIn = dataIn >> (4 * $urandom_range(0, 8));
        dpIn   = 8'($urandom);
        bright = 4'($urandom);
        lzbEn  = 1'($urandom);
      end
      applyStimulus();
    end

    $display("[TB] mid-frame reset");
    while ((t % FRAME) != 77) applyStimulus();
    #2 resetN = 1'b0;
    #1;
    setInactive();
    checkAll();
    @(negedge clk);
    @(negedge clk);
    checkAll();
    resetN = 1'b1;
    modelReset();
    setInactive();
    checkAll();
    n = 0;
    while (!frameDone && n < 400) begin
      applyStimulus();
      n++;
    end
    checkOutput("first_frame_done_delay", 32'(n), 32'(FRAME));
    runCycles(FRAME + 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
